// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding (forwarding built only with OPERAND_FORWARD_EN).
// Latency 1 cycle; stall holds the stage (operands still refresh from forwarding), flush loads a bubble.
module id_ex_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        idValid,
  input  logic [31:0] idReadData1,
  input  logic [31:0] idReadData2,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic [4:0]  idRd,
  input  logic [31:0] idImm,
  input  logic [3:0]  idAluControl,
  input  logic        idAluSrc,
  input  logic        idShiftOp,
  input  logic        idRegDst,
  input  logic        idRegWrite,
  input  logic        idMemRead,
  input  logic        idMemWrite,
  input  logic        idMemToReg,
  input  logic        exMemRegWrite,
  input  logic [4:0]  exMemRd,
  input  logic [31:0] exMemAluOut,
  input  logic        memWbRegWrite,
  input  logic [4:0]  memWbRd,
  input  logic [31:0] memWbData,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [3:0]  aluControl,
  output logic        exValid,
  output logic        exRegWrite,
  output logic        exMemRead,
  output logic        exMemWrite,
  output logic        exMemToReg,
  output logic [4:0]  exWriteReg,
  output logic [31:0] exStoreData,
  output logic [4:0]  exRs,
  output logic [4:0]  exRt
);

  typedef struct packed {
    logic regWrite;
    logic memRead;
    logic memWrite;
    logic memToReg;
  } ctrl_t;

  logic        r_valid;
  ctrl_t       r_ctrl;
  logic [3:0]  r_aluControl;
  logic        r_aluSrc;
  logic        r_shiftOp;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_writeReg;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [31:0] r_imm;

  logic [31:0] w_fwdA;
  logic [31:0] w_fwdB;
  logic [31:0] w_op1_stall;
  logic [31:0] w_op2_stall;
  ctrl_t       w_id_ctrl;

  assign w_id_ctrl = '{regWrite: idRegWrite & idValid,
                       memRead:  idMemRead  & idValid,
                       memWrite: idMemWrite & idValid,
                       memToReg: idMemToReg & idValid};

`ifdef OPERAND_FORWARD_EN
  // EX/MEM is the younger producer, so it is checked first; r0 is hardwired zero.
  always_comb begin
    w_fwdA = r_op1;
    if (exMemRegWrite && exMemRd == r_rs && r_rs != 5'd0)
      w_fwdA = exMemAluOut;
    else if (memWbRegWrite && memWbRd == r_rs && r_rs != 5'd0)
      w_fwdA = memWbData;
  end

  always_comb begin
    w_fwdB = r_op2;
    if (exMemRegWrite && exMemRd == r_rt && r_rt != 5'd0)
      w_fwdB = exMemAluOut;
    else if (memWbRegWrite && memWbRd == r_rt && r_rt != 5'd0)
      w_fwdB = memWbData;
  end

  // A stalled instruction must keep a producer's result once it leaves MEM/WB.
  assign w_op1_stall = w_fwdA;
  assign w_op2_stall = w_fwdB;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{exMemRegWrite, exMemRd, exMemAluOut,
                          memWbRegWrite, memWbRd, memWbData};
  assign w_fwdA      = r_op1;
  assign w_fwdB      = r_op2;
  assign w_op1_stall = r_op1;
  assign w_op2_stall = r_op2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_aluControl <= 4'd0;
      r_aluSrc     <= 1'b0;
      r_shiftOp    <= 1'b0;
      r_rs         <= 5'd0;
      r_rt         <= 5'd0;
      r_writeReg   <= 5'd0;
      r_op1        <= 32'd0;
      r_op2        <= 32'd0;
      r_imm        <= 32'd0;
    end else if (stall && !flush) begin
      r_op1 <= w_op1_stall;
      r_op2 <= w_op2_stall;
    end else begin
      r_valid      <= idValid & ~flush;
      r_ctrl       <= flush ? ctrl_t'('0) : w_id_ctrl;
      r_aluControl <= idAluControl;
      r_aluSrc     <= idAluSrc;
      r_shiftOp    <= idShiftOp;
      r_rs         <= idRs;
      r_rt         <= idRt;
      r_writeReg   <= idRegDst ? idRd : idRt;
      r_op1        <= idReadData1;
      r_op2        <= idReadData2;
      r_imm        <= idImm;
    end
  end

  assign in1         = r_shiftOp ? w_fwdB : w_fwdA;
  assign in2         = r_aluSrc ? r_imm : w_fwdB;
  assign exStoreData = w_fwdB;
  assign aluControl  = r_aluControl;
  assign exValid     = r_valid;
  assign exRegWrite  = r_ctrl.regWrite;
  assign exMemRead   = r_ctrl.memRead;
  assign exMemWrite  = r_ctrl.memWrite;
  assign exMemToReg  = r_ctrl.memToReg;
  assign exWriteReg  = r_writeReg;
  assign exRs        = r_rs;
  assign exRt        = r_rt;

endmodule
